// File: rtl/gpio_sequencer.sv
// Wishbone master that plays a table of GPIO words with a fixed interval; GPIO_SEQUENCER_TRIGGER_EN adds i_trigger start.
// Slave ack 1 clk after stb; first master write 2 clks after START, write spacing interval+3 with zero-wait ack.
// Slave never stalls; master holds stb through i_gp_stall and cyc until ack/err.
module gpio_sequencer #(
  parameter int          LGSTEPS          = 4,
  parameter logic [31:0] DEFAULT_INTERVAL = 32'd0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [LGSTEPS:0]   i_wb_addr,
  input  logic [31:0]        i_wb_data,
  output logic               o_wb_ack,
  output logic               o_wb_stall,
  output logic [31:0]        o_wb_data,
  output logic               o_gp_cyc,
  output logic               o_gp_stb,
  output logic               o_gp_we,
  output logic [31:0]        o_gp_data,
  input  logic               i_gp_ack,
  input  logic               i_gp_stall,
  input  logic               i_gp_err,
`ifdef GPIO_SEQUENCER_TRIGGER_EN
  input  logic               i_trigger,
`endif
  output logic               o_int
);

  localparam int NSTEPS = 1 << LGSTEPS;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAITACK, S_DELAY, S_NEXT
  } state_t;

  state_t             state;
  logic [LGSTEPS-1:0] step;
  logic [LGSTEPS-1:0] last;
  logic               loop_en;
  logic               err;
  logic               abort_pend;
  logic [31:0]        interval;
  logic [31:0]        cnt;
  logic [31:0]        tbl [NSTEPS];
  logic [31:0]        rd_dat;

  logic [LGSTEPS-1:0] tbl_idx;
  logic               sel_tbl, wr_tbl, wr_ctrl, wr_intv;
  logic               busy, abort_wr, start_req, trig_start, trigen;
  logic               in_bus, bus_err, bus_done;
  logic               unused_ok;

  assign tbl_idx   = i_wb_addr[LGSTEPS-1:0];
  assign sel_tbl   = i_wb_addr[LGSTEPS];
  assign wr_tbl    = i_wb_stb && i_wb_we && sel_tbl;
  assign wr_ctrl   = i_wb_stb && i_wb_we && !sel_tbl && !i_wb_addr[0];
  assign wr_intv   = i_wb_stb && i_wb_we && !sel_tbl && i_wb_addr[0];
  assign busy      = (state != S_IDLE);
  assign abort_wr  = wr_ctrl && i_wb_data[2];
  assign start_req = !abort_wr && ((wr_ctrl && i_wb_data[0]) || trig_start);
  assign o_wb_stall = 1'b0;
  assign unused_ok = &{1'b0, i_wb_cyc};

  // The ack can land in the same cycle the stb is accepted.
  assign in_bus   = (state == S_ISSUE) || (state == S_WAITACK);
  assign bus_err  = in_bus && i_gp_err;
  assign bus_done = ((state == S_ISSUE) && !i_gp_stall && i_gp_ack) ||
                    ((state == S_WAITACK) && i_gp_ack);

`ifdef GPIO_SEQUENCER_TRIGGER_EN
  logic trig_s1, trig_s2, trig_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
      trigen  <= 1'b0;
    end else begin
      trig_s1 <= i_trigger;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
      if (wr_ctrl) trigen <= i_wb_data[4];
    end
  end

  assign trig_start = trigen && trig_s2 && !trig_d;
`else
  assign trigen     = 1'b0;
  assign trig_start = 1'b0;
`endif

  // Table is plain storage; rewrites while busy are picked up at the next fetch.
  always_ff @(posedge i_clk) begin
    if (wr_tbl) tbl[tbl_idx] <= i_wb_data;
  end

  always_comb begin
    rd_dat = '0;
    if (sel_tbl) begin
      rd_dat = tbl[tbl_idx];
    end else if (i_wb_addr[0]) begin
      rd_dat = interval;
    end else begin
      rd_dat[0]             = busy;
      rd_dat[1]             = loop_en;
      rd_dat[3]             = err;
      rd_dat[4]             = trigen;
      rd_dat[8 +: LGSTEPS]  = last;
      rd_dat[16 +: LGSTEPS] = step;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack  <= i_wb_stb;
      o_wb_data <= rd_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      step       <= '0;
      last       <= '0;
      loop_en    <= 1'b0;
      err        <= 1'b0;
      abort_pend <= 1'b0;
      interval   <= DEFAULT_INTERVAL;
      cnt        <= '0;
      o_gp_cyc   <= 1'b0;
      o_gp_stb   <= 1'b0;
      o_gp_we    <= 1'b0;
      o_gp_data  <= '0;
      o_int      <= 1'b0;
    end else begin
      o_int <= 1'b0;
      if (wr_intv) interval <= i_wb_data;
      if (wr_ctrl) begin
        loop_en <= i_wb_data[1];
        if (i_wb_data[3]) err <= 1'b0;
        if (!busy) last <= i_wb_data[8 +: LGSTEPS];
      end
      if (in_bus && abort_wr) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_req) begin
            step       <= '0;
            err        <= 1'b0;
            abort_pend <= 1'b0;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort_wr) begin
            state <= S_IDLE;
          end else begin
            o_gp_data <= tbl[step];
            o_gp_cyc  <= 1'b1;
            o_gp_stb  <= 1'b1;
            o_gp_we   <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!i_gp_stall) begin
            o_gp_stb <= 1'b0;
            state    <= S_WAITACK;
          end
        end
        S_WAITACK: ;
        S_DELAY: begin
          if (abort_wr)       state <= S_IDLE;
          else if (cnt == '0) state <= S_NEXT;
          else                cnt   <= cnt - 32'd1;
        end
        S_NEXT: begin
          if (abort_wr) begin
            state <= S_IDLE;
          end else if (step == last) begin
            if (loop_en) begin
              step  <= '0;
              state <= S_FETCH;
            end else begin
              state <= S_IDLE;
              o_int <= 1'b1;
            end
          end else begin
            step  <= step + 1'b1;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Bus completion overrides the per-state transitions above.
      if (bus_err) begin
        err      <= 1'b1;
        o_gp_cyc <= 1'b0;
        o_gp_stb <= 1'b0;
        o_gp_we  <= 1'b0;
        o_int    <= 1'b1;
        state    <= S_IDLE;
      end else if (bus_done) begin
        o_gp_cyc <= 1'b0;
        o_gp_stb <= 1'b0;
        o_gp_we  <= 1'b0;
        if (abort_pend || abort_wr) begin
          state <= S_IDLE;
        end else if (interval == '0) begin
          state <= S_NEXT;
        end else begin
          cnt   <= interval - 32'd1;
          state <= S_DELAY;
        end
      end
    end
  end

endmodule

// File: doc/gpio_sequencer.md
Name: gpio_sequencer

Overview:
- Wishbone bus master that plays a programmed table of GPIO output words into the GPIO controller's single 32-bit register, with a fixed clock interval between writes.
- Each table word uses the GPIO write format: [31:16] change-enable mask, [15:0] new output values.
- The CPU configures the block through a Wishbone slave port. The block then generates timed output waveforms on its own, with no CPU involvement per edge.
- Sits between the peripheral bus (slave side) and the GPIO controller (master side).

Parameters:
- LGSTEPS, 4, log2 of table depth (table depth NSTEPS = 2^LGSTEPS words of 32 bits).
- DEFAULT_INTERVAL, 32'd0, reset value of the interval register.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  slave bus controls.
- i_wb_addr  in  LGSTEPS+1  slave word address.
- i_wb_data  in  32  slave write data.
- o_wb_ack  out  1  slave acknowledge.
- o_wb_stall  out  1  slave stall, tied 0.
- o_wb_data  out  32  slave read data.
- o_gp_cyc, o_gp_stb, o_gp_we  out  1 each  master bus controls to the GPIO controller.
- o_gp_data  out  32  master write data.
- i_gp_ack, i_gp_stall, i_gp_err  in  1 each  master responses.
- o_int  out  1  one-cycle pulse on sequence done or bus error.

Behaviour:
- Reset values: all outputs 0; state IDLE; step index 0; last index 0; loop 0; err 0; interval = DEFAULT_INTERVAL. Table contents are not reset.
- Slave address map:
  - addr MSB=1: table entry at index addr[LGSTEPS-1:0].
  - addr MSB=0, addr[0]=0: CTRL.
  - addr MSB=0, addr[0]=1: INTERVAL (32-bit).
- Slave timing:
  - o_wb_ack asserts one clock after any i_wb_stb; o_wb_data is valid in the ack cycle.
  - i_wb_cyc is ignored.
  - Table writes are allowed while busy; a rewritten entry takes effect the next time it is fetched.
- CTRL write fields:
  - bit0 START: ignored if busy.
  - bit1 LOOP.
  - bit2 ABORT.
  - bit3: write 1 clears err.
  - [8+LGSTEPS-1:8] last index: ignored if busy.
- CTRL read fields: bit0 busy, bit1 loop, bit3 err, [8+:LGSTEPS] last index, [16+:LGSTEPS] current step index. All other bits read 0.
- FSM:
  - IDLE: on START, set step index 0, clear err, go to FETCH.
  - FETCH: register the table entry into o_gp_data (1 cycle), then go to ISSUE.
  - ISSUE: o_gp_cyc=o_gp_stb=o_gp_we=1. Leave for WAITACK on the first cycle with !i_gp_stall (stb drops next cycle). If ack arrives in that same cycle, go directly to the post-ack decision.
  - WAITACK: hold o_gp_cyc=1 until i_gp_ack or i_gp_err, then drop cyc.
    - On ack with interval 0: go to NEXT.
    - On ack with interval nonzero: load counter with interval-1, go to DELAY.
  - DELAY: count down to 0, then go to NEXT. Write-to-write spacing is interval+3 clocks when there is no stall and ack is zero-wait.
  - NEXT:
    - If index == last and !LOOP: go IDLE, pulse o_int.
    - If index == last and LOOP: index wraps to 0, go FETCH.
    - Otherwise: index+1, go FETCH.
- Error handling: i_gp_err during ISSUE or WAITACK sets err, drops cyc, goes IDLE and pulses o_int.
- ABORT:
  - In IDLE: no effect.
  - In FETCH, DELAY or NEXT: go IDLE at the next clock, no o_int.
  - In ISSUE or WAITACK: the bus cycle finishes (ack/err), then go IDLE, no o_int.
  - START and ABORT in the same write: ABORT wins.
- Interval register: updates apply at the next load of the DELAY counter.
- Reset mid-operation: asynchronous return to reset values; o_gp_cyc drops immediately.

Optional Feature:
- Macro GPIO_SEQUENCER_TRIGGER_EN.
- Enabled:
  - Adds port i_trigger (in, 1).
  - i_trigger is synchronised through 2 FFs.
  - CTRL bit4 (TRIGEN, R/W, resets 0) enables it.
  - A synchronised rising edge while IDLE and TRIGEN=1 acts as START.
  - A rising edge while busy is ignored.
- Disabled: no i_trigger port; CTRL bit4 reads 0 and writes are ignored.

Test Plan:
- Single shot: table[0]=0x00010001, table[1]=0x00010000, last=1, interval=10, START, zero-wait ack.
  - Two master writes, in order, 13 clocks apart.
  - o_int pulses once; busy reads 0.
- Loop and abort: last=0, LOOP=1, interval=0.
  - Master write repeats every 3 clocks; step index stays 0.
  - ABORT written during DELAY-free ISSUE: the current write completes and no further stb follows.
- Stall/err: hold i_gp_stall for 5 clocks, then return i_gp_err.
  - stb held 5 clocks; err bit reads 1; o_int pulses; FSM returns to IDLE.
  - CTRL write 0x8 clears err.
- Busy protection: START with last=3, then mid-run write CTRL=0x00000201.
  - Last index stays 3; 4 writes issued.
  - Table[3] rewritten before fetch: the new value appears on o_gp_data.
- Async reset: assert i_reset_n=0 during WAITACK.
  - o_gp_cyc=0 in the same cycle; CTRL reads 0; interval reads DEFAULT_INTERVAL.
- Trigger (GPIO_SEQUENCER_TRIGGER_EN): TRIGEN=1, pulse i_trigger high for 1 clock.
  - First stb appears 4 clocks after the edge (2 sync + edge detect + FETCH).
  - A second pulse while busy is ignored.
